// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: machine word, predictor
// mode and the sequential next-PC helper.
package branch_predictor_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    BP_STATIC_NT = 1'b0,
    BP_BIMODAL   = 1'b1
  } bp_mode_t;

  localparam word_t PC_STEP = 32'd4;

  // Fall-through fetch address; wraps naturally at 32 bits.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundles the lookup, update and statistics signals of the branch predictor.
// bp: the predictor side. dp: the datapath side (fetch + execute).
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  word_t lookup_pc;
  logic  pred_taken;
  word_t pred_npc;
  logic  update_en;
  word_t update_pc;
  logic  update_taken;
  word_t update_target;
  logic  update_pred;
  logic  flush_all;
  word_t resolve_cnt;
  word_t mispred_cnt;

  modport bp (
    input  lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred, flush_all,
    output pred_taken, pred_npc, resolve_cnt, mispred_cnt
  );

  modport dp (
    output lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred, flush_all,
    input  pred_taken, pred_npc, resolve_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down counter step used on the predictor update
// path. inc and dec together (or neither) leave the value unchanged.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] nxt
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

  // Next counter value, clamped at both ends.
  always_comb begin
    nxt = cur;
    if (inc && !dec) begin
      if (cur != CTR_MAX) begin
        nxt = cur + CTR_W'(1);
      end else begin
        nxt = cur;
      end
    end else if (dec && !inc) begin
      if (cur != CTR_MIN) begin
        nxt = cur - CTR_W'(1);
      end else begin
        nxt = cur;
      end
    end else begin
      nxt = cur;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB. Lookup is combinational
// from the table state; training happens on the clock edge from execute-stage
// resolution. Also keeps saturating resolve/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int       ENTRIES = 16,
  parameter int       CTR_W   = 2,
  parameter bp_mode_t MODE    = BP_BIMODAL
) (
  input  logic            CLK,
  input  logic            nRST,
  branch_predictor_if.bp  bpif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  // Weakly-taken is the allocation value; weakly-not-taken is the reset/flush value.
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam word_t            CNT_MAX = 32'hFFFF_FFFF;

  // Table state
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  word_t              r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];

  // Statistics
  word_t r_resolve_cnt;
  word_t r_mispred_cnt;

  // Lookup path
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_pred_taken;
  word_t            w_pred_npc;

  // Update path
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [CTR_W-1:0] w_ctr_nxt;

  // Word-offset bits of the PCs are never used by the predictor.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{bpif.lookup_pc[1:0], bpif.update_pc[1:0]};

  assign w_lk_idx = bpif.lookup_pc[IDX_W+1:2];
  assign w_lk_tag = bpif.lookup_pc[31:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_up_idx = bpif.update_pc[IDX_W+1:2];
  assign w_up_tag = bpif.update_pc[31:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // One shared counter step for the single entry touched per update.
  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .cur (r_ctr[w_up_idx]),
    .inc (bpif.update_taken),
    .dec (!bpif.update_taken),
    .nxt (w_ctr_nxt)
  );

  // Direction and next-PC prediction from the pre-update table state.
  always_comb begin
    w_pred_taken = 1'b0;
    w_pred_npc   = pc_plus4(bpif.lookup_pc);
    if (MODE == BP_BIMODAL) begin
      w_pred_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
    end else begin
      w_pred_taken = 1'b0;
    end
    if (w_pred_taken) begin
      w_pred_npc = r_target[w_lk_idx];
    end else begin
      w_pred_npc = pc_plus4(bpif.lookup_pc);
    end
  end

  assign bpif.pred_taken  = w_pred_taken;
  assign bpif.pred_npc    = w_pred_npc;
  assign bpif.resolve_cnt = r_resolve_cnt;
  assign bpif.mispred_cnt = r_mispred_cnt;

  // Table training; flush overrides any same-cycle update.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= TAG_W'(0);
        r_target[i] <= 32'h0000_0000;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (bpif.flush_all) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_WNT;
      end
    end else if ((MODE == BP_BIMODAL) && bpif.update_en) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_nxt;
        if (bpif.update_taken) begin
          r_target[w_up_idx] <= bpif.update_target;
        end
      end else if (bpif.update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bpif.update_target;
        r_ctr[w_up_idx]    <= CTR_WT;
      end
    end
  end

  // Saturating statistics; they count every accepted update regardless of mode or flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_resolve_cnt <= 32'h0000_0000;
      r_mispred_cnt <= 32'h0000_0000;
    end else if (bpif.update_en) begin
      if (r_resolve_cnt != CNT_MAX) begin
        r_resolve_cnt <= r_resolve_cnt + 32'd1;
      end
      if ((bpif.update_pred != bpif.update_taken) && (r_mispred_cnt != CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (bimodal and static-NT).
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  branch_predictor_if bif();
  branch_predictor_if sif();

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(BP_BIMODAL)) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bpif (bif.bp)
  );

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(BP_STATIC_NT)) u_dut_snt (
    .CLK  (CLK),
    .nRST (nRST),
    .bpif (sif.bp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic  upd;
    word_t upd_pc;
    logic  upd_taken;
    word_t upd_target;
    logic  upd_pred;
    logic  flush;
    word_t lk_pc;
    logic  exp_taken;
    word_t exp_npc;
    word_t exp_res;
    word_t exp_mis;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic upd, input word_t upc, input logic ut,
                              input word_t utgt, input logic up, input logic fl,
                              input word_t lk, input logic et, input word_t en,
                              input word_t er, input word_t em);
    vec_t v;
    v.upd = upd; v.upd_pc = upc; v.upd_taken = ut; v.upd_target = utgt;
    v.upd_pred = up; v.flush = fl; v.lk_pc = lk; v.exp_taken = et;
    v.exp_npc = en; v.exp_res = er; v.exp_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic et, input word_t en,
                       input word_t er, input word_t em);
    chk({tag, " pred_taken"}, {31'd0, bif.pred_taken}, {31'd0, et});
    chk({tag, " pred_npc"}, bif.pred_npc, en);
    chk({tag, " resolve_cnt"}, bif.resolve_cnt, er);
    chk({tag, " mispred_cnt"}, bif.mispred_cnt, em);
  endtask

  task automatic idle_inputs();
    bif.update_en = 1'b0; bif.update_pc = 32'h0; bif.update_taken = 1'b0;
    bif.update_target = 32'h0; bif.update_pred = 1'b0; bif.flush_all = 1'b0;
    sif.update_en = 1'b0; sif.update_pc = 32'h0; sif.update_taken = 1'b0;
    sif.update_target = 32'h0; sif.update_pred = 1'b0; sif.flush_all = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b0;
    idle_inputs();
    bif.lookup_pc = 32'h0000_0040;
    sif.lookup_pc = 32'h0000_0040;

    //             upd  upd_pc        tk    target        pred  flush lookup        e_tk  e_npc         res    mis
    vecs[0]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd0,  32'd0);
    vecs[1]  = mk(1'b1, 32'h40,       1'b1, 32'h100,      1'b0, 1'b0, 32'h40,       1'b1, 32'h100,      32'd1,  32'd1);
    vecs[2]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h80,       1'b0, 32'h84,       32'd1,  32'd1);
    vecs[3]  = mk(1'b1, 32'h80,       1'b1, 32'h200,      1'b0, 1'b0, 32'h80,       1'b1, 32'h200,      32'd2,  32'd2);
    vecs[4]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd2,  32'd2);
    vecs[5]  = mk(1'b1, 32'h40,       1'b1, 32'h100,      1'b0, 1'b0, 32'h40,       1'b1, 32'h100,      32'd3,  32'd3);
    vecs[6]  = mk(1'b1, 32'h40,       1'b0, 32'h0,        1'b1, 1'b0, 32'h40,       1'b0, 32'h44,       32'd4,  32'd4);
    vecs[7]  = mk(1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd5,  32'd4);
    vecs[8]  = mk(1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd6,  32'd4);
    vecs[9]  = mk(1'b1, 32'h40,       1'b1, 32'h300,      1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd7,  32'd5);
    vecs[10] = mk(1'b1, 32'h40,       1'b1, 32'h300,      1'b0, 1'b0, 32'h40,       1'b1, 32'h300,      32'd8,  32'd6);
    vecs[11] = mk(1'b1, 32'h40,       1'b1, 32'h340,      1'b1, 1'b0, 32'h40,       1'b1, 32'h340,      32'd9,  32'd6);
    vecs[12] = mk(1'b1, 32'h40,       1'b1, 32'h340,      1'b1, 1'b0, 32'h40,       1'b1, 32'h340,      32'd10, 32'd6);
    vecs[13] = mk(1'b1, 32'h40,       1'b0, 32'h0,        1'b1, 1'b0, 32'h40,       1'b1, 32'h340,      32'd11, 32'd7);
    vecs[14] = mk(1'b1, 32'hC0,       1'b1, 32'h400,      1'b0, 1'b1, 32'hC0,       1'b0, 32'hC4,       32'd12, 32'd8);
    vecs[15] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd12, 32'd8);
    vecs[16] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h80,       1'b0, 32'h84,       32'd12, 32'd8);
    vecs[17] = mk(1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       1'b0, 32'h44,       32'd13, 32'd8);
    vecs[18] = mk(1'b1, 32'h40,       1'b1, 32'h500,      1'b0, 1'b0, 32'h40,       1'b1, 32'h500,      32'd14, 32'd9);
    vecs[19] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'd14, 32'd9);

    // Outputs while held in reset.
    #12;
    chk("rst_hold pred_taken", {31'd0, bif.pred_taken}, 32'd0);
    chk("rst_hold pred_npc", bif.pred_npc, 32'h44);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Main table-driven sequence on the bimodal instance.
    for (int i = 0; i < 20; i++) begin
      bif.update_en     = vecs[i].upd;
      bif.update_pc     = vecs[i].upd_pc;
      bif.update_taken  = vecs[i].upd_taken;
      bif.update_target = vecs[i].upd_target;
      bif.update_pred   = vecs[i].upd_pred;
      bif.flush_all     = vecs[i].flush;
      bif.lookup_pc     = vecs[i].lk_pc;
      @(posedge CLK); #1;
      bif.update_en = 1'b0;
      bif.flush_all = 1'b0;
      chk_b($sformatf("vec%0d", i), vecs[i].exp_taken, vecs[i].exp_npc,
            vecs[i].exp_res, vecs[i].exp_mis);
    end

    // Same-cycle lookup and update of one entry: pre-update state seen first.
    bif.lookup_pc     = 32'h1C0;
    bif.update_en     = 1'b1;
    bif.update_pc     = 32'h1C0;
    bif.update_taken  = 1'b1;
    bif.update_target = 32'h600;
    bif.update_pred   = 1'b0;
    #3;
    chk_b("nobypass_before", 1'b0, 32'h1C4, 32'd14, 32'd9);
    @(posedge CLK); #1;
    bif.update_en = 1'b0;
    chk_b("nobypass_after", 1'b1, 32'h600, 32'd15, 32'd10);
    bif.lookup_pc = 32'h40;
    #1;
    chk_b("alias_0x40_evicted", 1'b0, 32'h44, 32'd15, 32'd10);

    // Static-not-taken instance: table never trains, counters still count.
    for (int i = 0; i < 4; i++) begin
      sif.lookup_pc     = 32'h40;
      sif.update_en     = 1'b1;
      sif.update_pc     = 32'h40;
      sif.update_taken  = 1'b1;
      sif.update_target = 32'h100;
      sif.update_pred   = 1'b0;
      @(posedge CLK); #1;
      sif.update_en = 1'b0;
      chk($sformatf("snt%0d pred_taken", i), {31'd0, sif.pred_taken}, 32'd0);
      chk($sformatf("snt%0d pred_npc", i), sif.pred_npc, 32'h44);
    end
    chk("snt resolve_cnt", sif.resolve_cnt, 32'd4);
    chk("snt mispred_cnt", sif.mispred_cnt, 32'd4);

    // Reset arriving while an update is pending: the update is lost.
    @(negedge CLK);
    bif.lookup_pc     = 32'h1C0;
    bif.update_en     = 1'b1;
    bif.update_pc     = 32'h240;
    bif.update_taken  = 1'b1;
    bif.update_target = 32'h700;
    bif.update_pred   = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk_b("rst_async", 1'b0, 32'h1C4, 32'd0, 32'd0);
    @(posedge CLK); #2;
    nRST = 1'b1;
    bif.update_en = 1'b0;
    #1;
    chk_b("rst_after_1C0", 1'b0, 32'h1C4, 32'd0, 32'd0);
    bif.lookup_pc = 32'h240;
    #1;
    chk_b("rst_after_240", 1'b0, 32'h244, 32'd0, 32'd0);
    chk("rst_after snt resolve_cnt", sif.resolve_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised bimodal branch predictor with a direct-mapped branch target buffer, the next-generation fetch-stage block for the pipelined MIPS core. It replaces the fixed PC+4 next-PC with a predicted next PC, looked up in the same cycle as instruction fetch. It is trained by branch and jump resolution from the execute stage. It also keeps saturating performance counters for resolved and mispredicted branches.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CTR_W, 2, saturating-counter width, ≥1
- MODE, BP_BIMODAL, bp_mode_t: BP_STATIC_NT or BP_BIMODAL
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- lookup_pc  in  32  fetch PC (word aligned)
- pred_taken  out  1  predicted taken
- pred_npc  out  32  predicted next PC
- update_en  in  1  resolved control-flow instruction valid this cycle
- update_pc  in  32  PC of resolved instruction
- update_taken  in  1  actual direction
- update_target  in  32  actual target (meaningful when taken)
- update_pred  in  1  pred_taken carried down the pipe with this instruction
- flush_all  in  1  synchronous invalidate of every entry
- resolve_cnt  out  32  number of updates accepted, saturating
- mispred_cnt  out  32  number of direction mispredicts, saturating

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0] and ctr[CTR_W-1:0].
- Lookup is combinational from state: hit = valid[idx] && tag match.
  - BP_BIMODAL: pred_taken = hit && ctr[CTR_W-1].
  - BP_STATIC_NT: pred_taken = 0.
- pred_npc = pred_taken ? target[idx] : lookup_pc + 4, with 32-bit wrap.
- Update (BP_BIMODAL, on rising CLK with update_en):
  - Hit: ctr saturating +1 if taken, -1 if not taken, bounded to 0..2^CTR_W-1. target := update_target when taken.
  - Miss and taken: allocate (overwrite) the entry: valid=1, new tag, target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no table change.
- BP_STATIC_NT: the table is never written, but the counters still operate.
- Counters, on update_en:
  - resolve_cnt +1.
  - mispred_cnt +1 when update_pred != update_taken.
  - Both stick at 32'hFFFF_FFFF.
- flush_all: clears all valid bits and sets every ctr to 2^(CTR_W-1)-1 (weakly not taken). Counters are unaffected.
  - flush_all wins over a same-cycle update to the table; the counters still count that update.

## Timing
- Lookup latency is 0 cycles (combinational). An update becomes visible to lookup on the cycle after its clock edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state. There is no bypass.
- Reset (async, nRST=0):
  - all valid=0, ctr=2^(CTR_W-1)-1, resolve_cnt=mispred_cnt=0.
  - Outputs during and after reset: pred_taken=0, pred_npc=lookup_pc+4.
- Reset mid-update: the update is lost. State is the reset state on deassertion.
- There is no stall input. The datapath gates update_en with its pipeline enable so each instruction updates exactly once.

## Structure
- cpu_types_pkg gains bp_mode_t (BP_STATIC_NT, BP_BIMODAL) and reuses the existing word_t for PC and target.
- branch_predictor_if.vh bundles the lookup, update and counter signals, with modports bp and dp, matching the other pipeline interfaces.
- Sub-module sat_counter (parameter CTR_W): combinational next-value function with inputs cur, inc and dec. One instance per entry, or a shared instance on the update path.
- Table is a flop array: valid, tag, target and ctr vectors indexed by idx.

## Test plan
All scenarios use ENTRIES=16, CTR_W=2, BP_BIMODAL unless stated.
- Reset, then lookup_pc=0x40 -> pred_taken=0, pred_npc=0x44, resolve_cnt=0, mispred_cnt=0.
- Update pc=0x40, taken, target=0x100, pred=0.
  - Next cycle, lookup 0x40 -> pred_taken=1, pred_npc=0x100.
  - mispred_cnt=1, resolve_cnt=1.
- After the previous scenario, lookup 0x80 (same index 0, tag 2 vs 1) -> miss, pred_npc=0x84.
  - Then update 0x80 taken, target=0x200: 0x40 now misses and 0x80 predicts 0x200.
- Hysteresis on 0x40 starting from ctr=2:
  - three not-taken updates -> ctr 1, 0, 0 and pred_taken=0;
  - one taken -> ctr=1, still not taken;
  - a second taken -> ctr=2, pred_npc=target.
- flush_all asserted in the same cycle as a taken update to 0xC0:
  - afterwards every lookup misses, including 0xC0;
  - resolve_cnt still increments.
- MODE=BP_STATIC_NT with four taken updates (pred=0) to 0x40:
  - pred_taken stays 0 and pred_npc=0x44;
  - mispred_cnt=4.
